// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared judgement encodings, point values and combo tier limits
//
// Package contents:
//   judge_t        per-lane judgement code (2 bits per lane on the judgement bus)
//   PERFECT_PTS    base points for a PERFECT lane
//   GOOD_PTS       base points for a GOOD lane
//   TIERn_COMBO    combo thresholds where the multiplier steps x1 -> x2 -> x3 -> x4
//   LANE_CNT_W     width of a per-event lane count (up to 4 lanes)
package score_pkg;

  typedef enum logic [1:0] {
    JUDGE_PERFECT = 2'b00,
    JUDGE_GOOD    = 2'b01,
    JUDGE_MISS    = 2'b10,
    JUDGE_NO_NOTE = 2'b11
  } judge_t;

  localparam int PERFECT_PTS = 10;
  localparam int GOOD_PTS    = 5;

  localparam int TIER1_COMBO = 10;
  localparam int TIER2_COMBO = 30;
  localparam int TIER3_COMBO = 50;

  localparam int LANE_CNT_W = 3;

endpackage

// File: rtl/lane_tally.sv
// rtl/lane_tally.sv - combinational per-event lane counter
//
// Ports:
//   judgement  in   2*LANES  lane i at bits [2i+1:2i]
//   perfect_n  out  count of PERFECT lanes
//   good_n     out  count of GOOD lanes
//   miss_n     out  count of MISS lanes
//   hits_n     out  count of PERFECT + GOOD lanes
module lane_tally
  import score_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic [2*LANES-1:0]    judgement,
  output logic [LANE_CNT_W-1:0] perfect_n,
  output logic [LANE_CNT_W-1:0] good_n,
  output logic [LANE_CNT_W-1:0] miss_n,
  output logic [LANE_CNT_W-1:0] hits_n
);

  always_comb begin
    perfect_n = '0;
    good_n    = '0;
    miss_n    = '0;
    for (int i = 0; i < LANES; i++) begin
      case (judge_t'(judgement[2*i +: 2]))
        JUDGE_PERFECT: perfect_n = perfect_n + LANE_CNT_W'(1);
        JUDGE_GOOD:    good_n    = good_n + LANE_CNT_W'(1);
        JUDGE_MISS:    miss_n    = miss_n + LANE_CNT_W'(1);
        default:       ;
      endcase
    end
    hits_n = perfect_n + good_n;
  end

endmodule

// File: rtl/score_accumulator.sv
// rtl/score_accumulator.sv - rhythm-game score, combo and judgement tally accumulator
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   asynchronous active-high reset
//   clear        in   synchronous game restart, wins over a simultaneous event
//   judge_valid  in   judgement bus holds one event this cycle
//   judgement    in   2*LANES, lane i at [2i+1:2i]
//   score        out  SCORE_W saturating running total
//   combo        out  CNT_W current combo
//   max_combo    out  CNT_W highest combo this game
//   perfect_cnt, good_cnt, miss_cnt  out  CNT_W saturating tallies
//   score_upd    out  one-cycle pulse after an event
//   score_sat    out  sticky score-saturated flag
module score_accumulator
  import score_pkg::*;
#(
  parameter int LANES   = 2,
  parameter int SCORE_W = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               judge_valid,
  input  logic [2*LANES-1:0] judgement,
  output logic [SCORE_W-1:0] score,
  output logic [CNT_W-1:0]   combo,
  output logic [CNT_W-1:0]   max_combo,
  output logic [CNT_W-1:0]   perfect_cnt,
  output logic [CNT_W-1:0]   good_cnt,
  output logic [CNT_W-1:0]   miss_cnt,
  output logic               score_upd,
  output logic               score_sat
);

  // Base points for 4 PERFECT lanes x4 is 160, so 8 bits of gain suffice;
  // nine extra sum bits keep the carry out of the saturation compare.
  localparam int SUM_W = SCORE_W + 9;
  localparam int CMP_W = (CNT_W > 32) ? CNT_W : 32;

  logic [LANE_CNT_W-1:0] perfect_n, good_n, miss_n, hits_n;
  logic                  event_hit;
  logic [7:0]            base, gain;
  logic [CMP_W-1:0]      combo_wide;
  logic [SUM_W-1:0]      score_sum;
  logic                  sat_hit;
  logic [SCORE_W-1:0]    score_next;
  logic [CNT_W-1:0]      combo_inc;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [LANE_CNT_W-1:0] n);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W + 1)'(n);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  lane_tally #(.LANES(LANES)) u_lane_tally (
    .judgement (judgement),
    .perfect_n (perfect_n),
    .good_n    (good_n),
    .miss_n    (miss_n),
    .hits_n    (hits_n)
  );

  // An all-NO_NOTE bus is all ones, so one reduction finds a real event.
  assign event_hit  = judge_valid & ~(&judgement);
  assign combo_wide = CMP_W'(combo);

  // Products by the point constants fold to fixed shifts and adds.
  assign base = 8'(perfect_n) * 8'(PERFECT_PTS) + 8'(good_n) * 8'(GOOD_PTS);

  // Multiplier tier comes from the combo held before this event.
  always_comb begin
    gain = base;
    if (combo_wide < CMP_W'(TIER1_COMBO))      gain = base;
    else if (combo_wide < CMP_W'(TIER2_COMBO)) gain = base << 1;
    else if (combo_wide < CMP_W'(TIER3_COMBO)) gain = base + (base << 1);
    else                                       gain = base << 2;
  end

  assign score_sum  = SUM_W'(score) + SUM_W'(gain);
  assign sat_hit    = score_sum > SUM_W'({SCORE_W{1'b1}});
  assign score_next = sat_hit ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
  assign combo_inc  = sat_add(combo, hits_n);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score       <= '0;
      combo       <= '0;
      max_combo   <= '0;
      perfect_cnt <= '0;
      good_cnt    <= '0;
      miss_cnt    <= '0;
      score_upd   <= 1'b0;
      score_sat   <= 1'b0;
    end else if (clear) begin
      score       <= '0;
      combo       <= '0;
      max_combo   <= '0;
      perfect_cnt <= '0;
      good_cnt    <= '0;
      miss_cnt    <= '0;
      score_upd   <= 1'b0;
      score_sat   <= 1'b0;
    end else begin
      score_upd <= event_hit;
      if (event_hit) begin
        score       <= score_next;
        score_sat   <= score_sat | sat_hit;
        // Hits in a MISS event still score and still count toward max_combo.
        combo       <= (miss_n != '0) ? '0 : combo_inc;
        max_combo   <= (combo_inc > max_combo) ? combo_inc : max_combo;
        perfect_cnt <= sat_add(perfect_cnt, perfect_n);
        good_cnt    <= sat_add(good_cnt, good_n);
        miss_cnt    <= sat_add(miss_cnt, miss_n);
      end
    end
  end

endmodule

// File: tb/tb_score_accumulator.sv
// tb/tb_score_accumulator.sv - self-checking bench for score_accumulator
module tb_score_accumulator;

  typedef struct {
    longint score, combo, maxc, pc, gc, mc;
    bit     upd, sat;
  } ms_t;

  logic       clk = 1'b0;
  logic       rst, clear, judge_valid;
  logic [7:0] j4;
  logic [3:0] j2;
  assign j2 = j4[3:0];

  logic [15:0] a_score, a_combo, a_maxc, a_pc, a_gc, a_mc;
  logic        a_upd, a_sat;
  logic [7:0]  b_score;
  logic [5:0]  b_combo, b_maxc, b_pc, b_gc, b_mc;
  logic        b_upd, b_sat;

  int  total = 0;
  int  bad   = 0;
  bit  check_en = 1'b0;
  ms_t ma, mb;

  always #5 clk = ~clk;

  score_accumulator #(.LANES(2), .SCORE_W(16), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .judge_valid(judge_valid), .judgement(j2),
    .score(a_score), .combo(a_combo), .max_combo(a_maxc), .perfect_cnt(a_pc),
    .good_cnt(a_gc), .miss_cnt(a_mc), .score_upd(a_upd), .score_sat(a_sat)
  );

  score_accumulator #(.LANES(4), .SCORE_W(8), .CNT_W(6)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .judge_valid(judge_valid), .judgement(j4),
    .score(b_score), .combo(b_combo), .max_combo(b_maxc), .perfect_cnt(b_pc),
    .good_cnt(b_gc), .miss_cnt(b_mc), .score_upd(b_upd), .score_sat(b_sat)
  );

  function automatic ms_t zero_state();
    ms_t r;
    r = '{default: 0};
    return r;
  endfunction

  function automatic longint cap(longint v, longint mx);
    return (v > mx) ? mx : v;
  endfunction

  // Reference: apply one cycle of the game rules to the model state.
  function automatic ms_t step(ms_t s, int lanes, int sw, int cw, bit v, bit c, logic [7:0] j);
    ms_t    r;
    int     p, g, m;
    longint smax, cmax, mult, tot, inc;
    logic [1:0] code;
    r = s;
    p = 0; g = 0; m = 0;
    smax = (64'd1 << sw) - 1;
    cmax = (64'd1 << cw) - 1;
    if (c) return zero_state();
    for (int i = 0; i < lanes; i++) begin
      code = j[2*i +: 2];
      if (code == 2'd0) p++;
      else if (code == 2'd1) g++;
      else if (code == 2'd2) m++;
    end
    r.upd = 1'b0;
    if (!v || (p + g + m) == 0) return r;
    r.upd = 1'b1;
    mult  = (s.combo < 10) ? 1 : (s.combo < 30) ? 2 : (s.combo < 50) ? 3 : 4;
    tot   = s.score + (p * 10 + g * 5) * mult;
    r.sat   = s.sat || (tot > smax);
    r.score = cap(tot, smax);
    inc     = cap(s.combo + p + g, cmax);
    r.maxc  = (inc > s.maxc) ? inc : s.maxc;
    r.combo = (m > 0) ? 0 : inc;
    r.pc    = cap(s.pc + p, cmax);
    r.gc    = cap(s.gc + g, cmax);
    r.mc    = cap(s.mc + m, cmax);
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= zero_state();
      mb <= zero_state();
    end else begin
      ma <= step(ma, 2, 16, 16, judge_valid, clear, {4'hF, j2});
      mb <= step(mb, 4, 8, 6, judge_valid, clear, j4);
    end
  end

  task automatic cmp(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (check_en) begin
      cmp("a_score", a_score, ma.score);  cmp("a_combo", a_combo, ma.combo);
      cmp("a_maxc", a_maxc, ma.maxc);     cmp("a_pc", a_pc, ma.pc);
      cmp("a_gc", a_gc, ma.gc);           cmp("a_mc", a_mc, ma.mc);
      cmp("a_upd", a_upd, ma.upd);        cmp("a_sat", a_sat, ma.sat);
      cmp("b_score", b_score, mb.score);  cmp("b_combo", b_combo, mb.combo);
      cmp("b_maxc", b_maxc, mb.maxc);     cmp("b_pc", b_pc, mb.pc);
      cmp("b_gc", b_gc, mb.gc);           cmp("b_mc", b_mc, mb.mc);
      cmp("b_upd", b_upd, mb.upd);        cmp("b_sat", b_sat, mb.sat);
    end
  end

  task automatic drive(input bit v, input logic [7:0] j, input bit c);
    judge_valid = v;
    j4          = j;
    clear       = c;
    @(negedge clk);
  endtask

  function automatic logic [7:0] rand_bus(input bit allow_miss);
    logic [7:0] r;
    int         k;
    r = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      k = $urandom_range(0, 9);
      if (k <= 4)                   r[2*i +: 2] = 2'b00;
      else if (k <= 6)              r[2*i +: 2] = 2'b01;
      else if (k == 7 && allow_miss) r[2*i +: 2] = 2'b10;
      else                          r[2*i +: 2] = 2'b11;
    end
    return r;
  endfunction

  initial begin
    rst = 1'b1; clear = 1'b0; judge_valid = 1'b0; j4 = 8'hFF;
    repeat (3) @(negedge clk);
    cmp("rst_score", a_score, 0);
    cmp("rst_upd", a_upd, 0);
    rst = 1'b0;
    check_en = 1'b1;

    // First event after reset: lane0 PERFECT, lane1 NO_NOTE.
    drive(1, 8'hFC, 0);
    cmp("r30_score", a_score, 10);
    cmp("r30_combo", a_combo, 1);
    cmp("r30_pc", a_pc, 1);
    cmp("r30_upd", a_upd, 1);
    drive(0, 8'hFF, 0);
    cmp("r30_upd_drop", a_upd, 0);

    // {GOOD, PERFECT}
    drive(0, 8'hFF, 1);
    drive(1, 8'hF1, 0);
    cmp("r31_score", a_score, 15);
    cmp("r31_combo", a_combo, 2);
    cmp("r31_maxc", a_maxc, 2);
    cmp("r31_gc", a_gc, 1);
    cmp("r31_pc", a_pc, 1);

    // Tier step at combo 10.
    drive(0, 8'hFF, 1);
    repeat (10) drive(1, 8'hFC, 0);
    cmp("r32_score10", a_score, 100);
    cmp("r32_combo10", a_combo, 10);
    drive(1, 8'hFC, 0);
    cmp("r32_score11", a_score, 120);
    cmp("r32_combo11", a_combo, 11);

    // MISS with a hit in the same event.
    drive(0, 8'hFF, 1);
    repeat (5) drive(1, 8'hFC, 0);
    drive(1, 8'hF8, 0);
    cmp("r33_score", a_score, 60);
    cmp("r33_combo", a_combo, 0);
    cmp("r33_maxc", a_maxc, 6);
    cmp("r33_mc", a_mc, 1);

    // 8-bit score saturation on the 4-lane instance.
    drive(0, 8'hFF, 1);
    repeat (8) drive(1, 8'h80, 0);
    drive(1, 8'hBC, 0);
    cmp("r34_score250", b_score, 250);
    cmp("r34_sat_pre", b_sat, 0);
    drive(1, 8'hFC, 0);
    cmp("r34_score_sat", b_score, 255);
    cmp("r34_sat", b_sat, 1);
    drive(1, 8'hFC, 0);
    cmp("r34_score_hold", b_score, 255);

    // clear beats a simultaneous event; all-NO_NOTE changes nothing.
    drive(1, 8'hFC, 1);
    cmp("r35_score", a_score, 0);
    cmp("r35_combo", a_combo, 0);
    cmp("r35_pc", a_pc, 0);
    cmp("r35_upd", a_upd, 0);
    cmp("r35_bsat", b_sat, 0);
    drive(1, 8'hF1, 0);
    drive(1, 8'hFF, 0);
    cmp("r35_nonote_score", a_score, 15);
    cmp("r35_nonote_upd", a_upd, 0);

    // Randomized traffic; a no-miss window drives combos into saturation.
    for (int i = 0; i < 4000; i++) begin
      if (i == 2500) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      drive(($urandom_range(0, 3) != 0), rand_bus(!(i >= 1000 && i < 1600)),
            ($urandom_range(0, 299) == 0));
    end

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_accumulator.md
SCORE_ACCUMULATOR -- requirements
Module: score_accumulator

Interface
REQ-001 SHALL provide parameter LANES, default 2, number of judgement lanes (1..4).
REQ-002 SHALL provide parameter SCORE_W, default 16, width of the score total.
REQ-003 SHALL provide parameter CNT_W, default 16, width of the combo and tally counters.
REQ-004 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL provide port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL provide port clear  input  1  synchronous game restart.
REQ-007 SHALL provide port judge_valid  input  1  strobe; judgement bus holds one event this cycle.
REQ-008 SHALL provide port judgement  input  2*LANES  lane i at bits [2i+1:2i]; PERFECT=00, GOOD=01, MISS=10, NO_NOTE=11.
REQ-009 SHALL provide port score  output  SCORE_W  registered running total.
REQ-010 SHALL provide port combo  output  CNT_W  registered current combo.
REQ-011 SHALL provide port max_combo  output  CNT_W  registered highest combo this game.
REQ-012 SHALL provide ports perfect_cnt, good_cnt, miss_cnt  output  CNT_W each  registered tallies.
REQ-013 SHALL provide port score_upd  output  1  one-cycle pulse when an event changed state.
REQ-014 SHALL provide port score_sat  output  1  sticky flag: score has saturated.

Function
REQ-015 An event SHALL be a cycle with judge_valid=1 and at least one lane not NO_NOTE; all-NO_NOTE or judge_valid=0 SHALL change no state.
REQ-016 Results of an event in cycle t SHALL be visible on outputs in cycle t+1; score_upd SHALL pulse high in cycle t+1 only.
REQ-017 Base points SHALL be the sum over lanes of PERFECT_PTS (10) per PERFECT and GOOD_PTS (5) per GOOD; MISS and NO_NOTE SHALL score 0.
REQ-018 Multiplier SHALL derive from combo before the event: combo<10 x1, <30 x2, <50 x3, otherwise x4; realised by shift-add, no multiplier instance.
REQ-019 score SHALL add base*multiplier, saturating at 2^SCORE_W-1; on saturation score_sat SHALL set and hold until rst or clear.
REQ-020 hits = count of PERFECT+GOOD lanes; with no MISS in the event, combo SHALL become combo+hits, saturating at 2^CNT_W-1.
REQ-021 With any MISS in the event, points of that event's hits SHALL still be added, then combo SHALL become 0.
REQ-022 max_combo SHALL become max(max_combo, combo+hits) in every event, including events containing a MISS.
REQ-023 perfect_cnt, good_cnt, miss_cnt SHALL each add their lane counts for the event, saturating at 2^CNT_W-1.
REQ-024 clear SHALL zero all outputs the next cycle and SHALL take priority over a simultaneous event, whose effect SHALL be discarded.

Reset
REQ-025 rst SHALL asynchronously force score, combo, max_combo, all tallies, score_upd and score_sat to 0.
REQ-026 After rst deasserts, the first event SHALL be processed normally with multiplier x1.

Structure
REQ-027 Judgement encodings, PERFECT_PTS, GOOD_PTS and combo tier thresholds (10/30/50) SHALL live in shared package score_pkg.
REQ-028 Per-event lane counting (perfect, good, miss, hits counts) SHALL be a combinational sub-module lane_tally parametrised by LANES.
REQ-029 All outputs SHALL be driven directly from registers.

Verification
REQ-030 Reset then event {lane0 PERFECT, lane1 NO_NOTE} -> next cycle score=10, combo=1, perfect_cnt=1, score_upd=1 for one cycle.
REQ-031 From reset, event {GOOD, PERFECT} -> score=15, combo=2, max_combo=2, good_cnt=1, perfect_cnt=1.
REQ-032 Ten single-PERFECT events (score=100, combo=10), then one more PERFECT -> score=120 (x2), combo=11.
REQ-033 At combo=5, event {PERFECT, MISS} -> score+10, combo=0, max_combo=6, miss_cnt+1.
REQ-034 SCORE_W=8, score=250, event PERFECT at combo<10 -> score=255, score_sat=1; a further event leaves score=255.
REQ-035 clear asserted with a simultaneous PERFECT event -> all outputs 0 next cycle; judge_valid=1 with all NO_NOTE -> no change, no score_upd.
